// File: rtl/cfu_requant_pack.sv
// Output stage of the CFU MAC path: TFLite int8 requantization of 32-bit accumulators
// (multiplier/shift, offset, clamp) in a 3-stage pipeline, then packing of four int8 results per word.
module cfu_requant_pack #(
    parameter int LANES   = 4,
    parameter int SHIFT_W = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_we,
    input  logic [31:0]        cfg_mult,
    input  logic [SHIFT_W-1:0] cfg_shift,
    input  logic [31:0]        cfg_out_offset,
    input  logic [7:0]         cfg_act_min,
    input  logic [7:0]         cfg_act_max,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        in_acc,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_data,
    output logic [2:0]         out_count,
    output logic               busy
);
    localparam int LW = $clog2(LANES);

    logic [31:0]               mult_q, offset_q;
    logic signed [SHIFT_W-1:0] shift_q;
    logic [7:0]                min_q, max_q;

    logic                v1, v2, v3;
    logic signed [63:0]  s1_prod;
    logic                s1_sat;
    logic [31:0]         s2_q;
    logic [7:0]          s3_res;
    logic [LW-1:0]       lane_idx;
    logic [8*(LANES-1)-1:0] pk_word;
    logic                flush_pend;

    logic pk_adv, s1_en, s2_en, s3_en, pk_wr, fl_go, pipe_busy;

    // Each stage loads when empty or when the stage downstream moves.
    always_comb begin
        pk_adv    = !out_valid || out_ready;
        s3_en     = !v3 || pk_adv;
        s2_en     = !v2 || s3_en;
        s1_en     = !v1 || s2_en;
        in_ready  = s1_en;
        pk_wr     = v3 && pk_adv;
        pipe_busy = v1 || v2 || v3;
        fl_go     = flush_pend && !pipe_busy && pk_adv;
        busy      = pipe_busy || (lane_idx != '0) || out_valid || flush_pend;
    end

    // S1: pre-shift and 32x32 signed product
    logic [4:0]         lsh;
    logic [31:0]        x;
    logic signed [63:0] prod_c;
    always_comb begin
        lsh    = (shift_q > 0) ? shift_q[4:0] : 5'd0;
        x      = in_acc << lsh;
        prod_c = $signed({{32{x[31]}}, x}) * $signed({{32{mult_q[31]}}, mult_q});
    end

    // S2: saturating rounding doubling high multiply, then rounding right shift
    logic signed [63:0] nudge, sum, sum_adj, r_ext, q64;
    logic [31:0]        r;
    logic [5:0]         rsh;
    logic [63:0]        mask, rem, thr;
    always_comb begin
        nudge   = s1_prod[63] ? (64'sd1 - 64'sd1073741824) : 64'sd1073741824;
        sum     = s1_prod + nudge;
        sum_adj = sum[63] ? (sum + 64'sd2147483647) : sum;
        r       = s1_sat ? 32'h7fff_ffff : sum_adj[62:31];
        rsh     = (shift_q <= 0) ? 6'(-shift_q) : 6'd0;
        mask    = (64'd1 << rsh) - 64'd1;
        r_ext   = $signed({{32{r[31]}}, r});
        rem     = r_ext & mask;
        thr     = (mask >> 1) + {63'd0, r[31]};
        q64     = (r_ext >>> rsh) + ((rem > thr) ? 64'sd1 : 64'sd0);
    end

    // S3: offset and clamp
    logic signed [31:0] y, lo, hi;
    logic [7:0]         res_c;
    always_comb begin
        y  = s2_q + offset_q;
        lo = {{24{min_q[7]}}, min_q};
        hi = {{24{max_q[7]}}, max_q};
        if (y < lo)      res_c = min_q;
        else if (y > hi) res_c = max_q;
        else             res_c = y[7:0];
    end

    logic unused_bits;
    assign unused_bits = ^{sum_adj[63], sum_adj[30:0], q64[63:32]};

    always_ff @(posedge clk) begin
        if (reset) begin
            mult_q   <= 32'h4000_0000;
            shift_q  <= '0;
            offset_q <= '0;
            min_q    <= 8'h80;
            max_q    <= 8'h7f;
        end else if (cfg_we) begin
            mult_q   <= cfg_mult;
            shift_q  <= cfg_shift;
            offset_q <= cfg_out_offset;
            min_q    <= cfg_act_min;
            max_q    <= cfg_act_max;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v1 <= 1'b0; v2 <= 1'b0; v3 <= 1'b0;
            s1_prod <= '0; s1_sat <= 1'b0; s2_q <= '0; s3_res <= '0;
        end else begin
            if (s1_en) begin
                v1      <= in_valid;
                s1_prod <= prod_c;
                s1_sat  <= (x == 32'h8000_0000) && (mult_q == 32'h8000_0000);
            end
            if (s2_en) begin
                v2   <= v1;
                s2_q <= q64[31:0];
            end
            if (s3_en) begin
                v3     <= v2;
                s3_res <= res_c;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lane_idx   <= '0;
            pk_word    <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_count  <= '0;
            flush_pend <= 1'b0;
        end else begin
            if (pk_adv) out_valid <= 1'b0;
            if (pk_wr) begin
                if (lane_idx == LW'(LANES - 1)) begin
                    out_data  <= {s3_res, pk_word};
                    out_count <= 3'(LANES);
                    out_valid <= 1'b1;
                    lane_idx  <= '0;
                    pk_word   <= '0;
                end else begin
                    for (int i = 0; i < LANES - 1; i++)
                        if (lane_idx == LW'(i)) pk_word[i*8 +: 8] <= s3_res;
                    lane_idx <= lane_idx + 1'b1;
                end
            end else if (fl_go && lane_idx != '0) begin
                // Unused upper lanes are already zero in pk_word.
                out_data  <= {8'h00, pk_word};
                out_count <= 3'(lane_idx);
                out_valid <= 1'b1;
                lane_idx  <= '0;
                pk_word   <= '0;
            end
            if (fl_go) flush_pend <= 1'b0;
            if (flush && (pipe_busy || lane_idx != '0 || (in_valid && in_ready)))
                flush_pend <= 1'b1;
        end
    end
endmodule

// File: tb/tb_cfu_requant_pack.sv
// Directed bench for cfu_requant_pack: hand-computed requant results, packing, flush,
// backpressure and mid-stream reset.
module tb_cfu_requant_pack;
    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_we;
    logic [31:0] cfg_mult;
    logic [5:0]  cfg_shift;
    logic [31:0] cfg_out_offset;
    logic [7:0]  cfg_act_min, cfg_act_max;
    logic        in_valid, in_ready;
    logic [31:0] in_acc;
    logic        flush;
    logic        out_valid, out_ready;
    logic [31:0] out_data;
    logic [2:0]  out_count;
    logic        busy;

    int checks = 0;
    int errors = 0;

    cfu_requant_pack dut (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_mult(cfg_mult), .cfg_shift(cfg_shift),
        .cfg_out_offset(cfg_out_offset), .cfg_act_min(cfg_act_min), .cfg_act_max(cfg_act_max),
        .in_valid(in_valid), .in_ready(in_ready), .in_acc(in_acc), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_count(out_count), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic write_cfg(input logic [31:0] m, input logic [5:0] s, input logic [31:0] off,
                             input logic [7:0] mn, input logic [7:0] mx);
        cfg_mult = m; cfg_shift = s; cfg_out_offset = off; cfg_act_min = mn; cfg_act_max = mx;
        cfg_we = 1'b1;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [31:0] v, output bit ok);
        bit done;
        done = 0; ok = 0;
        in_valid = 1'b1; in_acc = v;
        for (int i = 0; i < 200 && !done; i++) begin
            #1;
            if (in_ready) begin done = 1; ok = 1; end
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic send_chk(input logic [31:0] v, input string nm);
        bit ok;
        send(v, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL %s accept timeout acc=%h", nm, v); end
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
    endtask

    task automatic wait_word(input logic [31:0] exp_d, input logic [2:0] exp_c, input string nm);
        bit got;
        got = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            #1;
            if (out_valid) begin
                got = 1;
                checks++;
                if (out_data !== exp_d) begin
                    errors++; $display("FAIL %s data got %h exp %h", nm, out_data, exp_d);
                end
                checks++;
                if (out_count !== exp_c) begin
                    errors++; $display("FAIL %s count got %0d exp %0d", nm, out_count, exp_c);
                end
            end
            @(negedge clk);
        end
        if (!got) begin checks++; errors++; $display("FAIL %s out_valid timeout got 0 exp 1", nm); end
    endtask

    task automatic test_reset();
        checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL rst_in_ready got %b exp 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
        checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL rst_out_data got %h exp 0", out_data); end
        checks++; if (out_count !== 3'd0) begin errors++; $display("FAIL rst_out_count got %0d exp 0", out_count); end
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
    endtask

    // 100 * 0.5 = 50 (rounded), -128 offset -> -78 = 0xB2
    task automatic test_back_to_back();
        logic [3:0] ov;
        write_cfg(32'h4000_0000, 6'd0, 32'hffff_ff80, 8'h80, 8'h7f);
        for (int i = 0; i < 4; i++) send_chk(32'd100, "b2b_send");
        for (int k = 0; k < 4; k++) begin
            #1; ov[k] = out_valid;
            if (k < 3) @(negedge clk);
        end
        checks++;
        if (ov !== 4'b1000) begin errors++; $display("FAIL b2b_latency out_valid trace got %b exp 1000", ov); end
        checks++; if (out_data !== 32'hB2B2_B2B2) begin errors++; $display("FAIL b2b_data got %h exp B2B2B2B2", out_data); end
        checks++; if (out_count !== 3'd4) begin errors++; $display("FAIL b2b_count got %0d exp 4", out_count); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_consumed got %b exp 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle_busy got %b exp 0", busy); end
    endtask

    // 101 * 0.5 -> 51, round-shift by 1 -> 26
    task automatic test_flush_shift();
        write_cfg(32'h4000_0000, 6'h3f, 32'h0, 8'h80, 8'h7f);
        send_chk(32'd101, "flush_send");
        pulse_flush();
        wait_word(32'h0000_001A, 3'd1, "flush_shift");
    endtask

    task automatic test_saturation();
        write_cfg(32'h4000_0000, 6'd0, 32'h0, 8'h80, 8'h7f);
        send_chk(32'd10000, "sat_hi_send");
        pulse_flush();
        wait_word(32'h0000_007F, 3'd1, "sat_hi");
        send_chk(-32'sd10000, "sat_lo_send");
        pulse_flush();
        wait_word(32'h0000_0080, 3'd1, "sat_lo");
        write_cfg(32'h4000_0000, 6'd0, 32'h0, 8'hF6, 8'h0A);
        send_chk(32'd100, "clamp_send");
        pulse_flush();
        wait_word(32'h0000_000A, 3'd1, "clamp_10");
    endtask

    task automatic test_srdhm_edge();
        write_cfg(32'h8000_0000, 6'd0, 32'h0, 8'h80, 8'h7f);
        send_chk(32'h8000_0000, "srdhm_send");
        pulse_flush();
        wait_word(32'h0000_007F, 3'd1, "srdhm_edge");
    endtask

    task automatic test_flush_empty();
        pulse_flush();
        repeat (3) @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_empty_valid got %b exp 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_empty_busy got %b exp 0", busy); end
    endtask

    // acc 10*i -> 5*i
    task automatic test_backpressure();
        bit saw_stall;
        saw_stall = 0;
        write_cfg(32'h4000_0000, 6'd0, 32'h0, 8'h80, 8'h7f);
        out_ready = 1'b0;
        fork
            begin
                for (int i = 1; i <= 12; i++) send_chk(32'(i * 10), "bp_send");
            end
            begin
                repeat (20) begin
                    @(negedge clk); #2;
                    if (!in_ready) saw_stall = 1;
                end
                checks++; if (!saw_stall) begin errors++; $display("FAIL bp_in_ready_drop got 1 exp 0"); end
                checks++; if (out_valid !== 1'b1 || out_data !== 32'h140F_0A05) begin
                    errors++; $display("FAIL bp_hold got v=%b d=%h exp v=1 d=140F0A05", out_valid, out_data);
                end
                @(negedge clk);
                out_ready = 1'b1;
                wait_word(32'h140F_0A05, 3'd4, "bp_word0");
                wait_word(32'h2823_1E19, 3'd4, "bp_word1");
                wait_word(32'h3C37_322D, 3'd4, "bp_word2");
            end
        join
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_idle_busy got %b exp 0", busy); end
    endtask

    task automatic test_mid_reset();
        bit leak;
        leak = 0;
        write_cfg(32'h4000_0000, 6'd0, 32'hffff_ff80, 8'h80, 8'h7f);
        for (int i = 0; i < 4; i++) send_chk(32'd100, "mr_send");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mr_busy got %b exp 0", busy); end
        reset = 1'b0;
        repeat (6) begin
            #1; if (out_valid) leak = 1;
            @(negedge clk);
        end
        checks++; if (leak) begin errors++; $display("FAIL mr_no_word got 1 exp 0"); end
        // config back at defaults: offset 0, acc 2,4,6,8 -> 1,2,3,4
        send_chk(32'd2, "mr_send2"); send_chk(32'd4, "mr_send2");
        send_chk(32'd6, "mr_send2"); send_chk(32'd8, "mr_send2");
        wait_word(32'h0403_0201, 3'd4, "mr_clean_word");
    endtask

    initial begin
        reset = 1'b1; cfg_we = 1'b0; cfg_mult = '0; cfg_shift = '0; cfg_out_offset = '0;
        cfg_act_min = '0; cfg_act_max = '0; in_valid = 1'b0; in_acc = '0; flush = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        test_reset();
        test_back_to_back();
        test_flush_shift();
        test_saturation();
        test_srdhm_edge();
        test_flush_empty();
        test_backpressure();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
